mmio_controller: RTL and testbench
==================================

MMIO_CONTROLLER -- requirements
Module: mmio_controller

Interface
REQ-001 SHALL have parameter DATA_W, default 16, CPU data bus width.
REQ-002 SHALL have parameter ADDR_W, default 16, CPU address width.
REQ-003 SHALL have parameter N_BTN, default 4, button count (1..DATA_W).
REQ-004 SHALL have parameter N_SW, default 10, switch count (1..DATA_W).
REQ-005 SHALL have parameter N_LEDR, default 10, red LED count (1..DATA_W).
REQ-006 SHALL have parameter N_LEDG, default 8, green LED count (1..DATA_W).
REQ-007 SHALL have parameter DEB_CYCLES, default 16, debounce stability length in clocks (>=2).
REQ-008 SHALL have port clk, input, 1, sole clock; all state changes on rising edge.
REQ-009 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-010 SHALL have port oe, input, 1, CPU direction: 1 = CPU writes (drives data), 0 = CPU reads.
REQ-011 SHALL have port addr, input, ADDR_W, CPU address.
REQ-012 SHALL have port buttons, input, N_BTN, raw asynchronous buttons, active-low.
REQ-013 SHALL have port switches, input, N_SW, raw switches, active-high, read unsynchronised-free (see REQ-024).
REQ-014 SHALL have port led_r, output, N_LEDR, red LED register.
REQ-015 SHALL have port led_g, output, N_LEDG, green LED register.
REQ-016 SHALL have port control_mem, output, 5, external SRAM controls {we, ce, oe, lb, ub}, all active-low.
REQ-017 SHALL have port data, inout, DATA_W, shared CPU/memory data bus.

Function
REQ-018 Address map (top of space, A = all-ones): A = LEDG, A-1 = LEDR, A-2 = BTN level, A-3 = SW, A-4 = BTN event flags; all other addresses = memory.
REQ-019 Memory address, oe=1 -> control_mem = 5'b00100; oe=0 -> 5'b10000; any I/O address -> 5'b11111; combinational from addr/oe.
REQ-020 Block SHALL drive data only when oe=0 and addr is an I/O address; otherwise data is high-Z.
REQ-021 Read values: zero-extended to DATA_W; LEDG -> led_g; LEDR -> led_r; BTN level -> debounced pressed state (1 = pressed); SW -> synchronised switches; EVT -> event flags.
REQ-022 Write oe=1 to LEDG/LEDR -> register loads data[N-1:0] at next rising edge; visible on led_* one cycle later; upper data bits ignored.
REQ-023 Writes to BTN level and SW addresses SHALL be ignored.
REQ-024 Buttons and switches SHALL each pass a 2-flop synchroniser; buttons inverted after synchronisation.
REQ-025 Per-button debouncer: counter resets to 0 whenever synchronised input equals debounced state; otherwise increments; when count reaches DEB_CYCLES-1 debounced state takes synchronised value and counter returns to 0.
REQ-026 Debounced 0->1 transition of button i SHALL set event flag i in the same edge the debounced state changes.
REQ-027 Event flags cleared write-1-to-clear: oe=1 at EVT clears flag i where data[i]=1; data bits >= N_BTN ignored.
REQ-028 Same-cycle set and clear of one flag -> set wins (flag remains 1).
REQ-029 Debounced 1->0 (release) SHALL not alter flags; flags stay set until cleared.
REQ-030 Glitch shorter than DEB_CYCLES synchronised cycles SHALL produce no level change and no event.
REQ-031 Addr/oe are sampled only at the write edge; no multi-cycle CPU handshake.

Reset
REQ-032 reset=1 SHALL asynchronously clear led_r, led_g, event flags, debounced states (released), debounce counters, and synchroniser flops to "not pressed"/0.
REQ-033 During reset control_mem SHALL still follow REQ-019 combinationally; data bus follows REQ-020 with cleared values.
REQ-034 Reset asserted mid-debounce SHALL discard partial count; no event generated on release of reset.

Verification
REQ-035 Write 16'h03FF to A-1, oe=1 -> led_r = 10'h3FF next cycle; read A-1, oe=0 -> data = 16'h03FF; control_mem = 5'b11111.
REQ-036 buttons[0] held low 20 cycles (DEB_CYCLES=16) -> BTN level bit0 = 1 within 2+16 cycles; EVT = 16'h0001.
REQ-037 buttons[1] low 5 cycles then high -> BTN level and EVT bit1 stay 0.
REQ-038 EVT = 16'h0003, write 16'h0001 to A-4 -> EVT = 16'h0002; write coinciding with new bit0 press -> bit0 stays 1.
REQ-039 addr 16'h1234, oe=1 -> control_mem = 5'b00100, data high-Z from block; oe=0 -> 5'b10000.
REQ-040 led_g = 8'hA5, assert reset asynchronously mid-cycle -> led_g = 0 immediately, EVT = 0.

Source files
------------

// File: rtl/mmio_controller.sv
// mmio_controller
//   Memory-mapped I/O front end for a small CPU. The top five addresses of the
//   CPU address space select on-board peripherals; every other address goes to
//   an external asynchronous SRAM whose active-low strobes are generated here.
//
//   Address map (A = all ones):
//     A   : green LED register (read/write)
//     A-1 : red LED register   (read/write)
//     A-2 : debounced button level, 1 = pressed (read only)
//     A-3 : synchronised switches (read only)
//     A-4 : button press event flags (read, write-1-to-clear)
//
// Ports
//   clk         : sole clock, rising edge
//   reset       : asynchronous active-high reset
//   oe          : CPU direction, 1 = CPU writes, 0 = CPU reads
//   addr        : CPU address
//   buttons     : raw asynchronous push buttons, active-low
//   switches    : raw asynchronous slide switches, active-high
//   led_r       : red LED register
//   led_g       : green LED register
//   control_mem : SRAM strobes {we, ce, oe, lb, ub}, all active-low
//   data        : shared bidirectional CPU / memory data bus
module mmio_controller #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 16,
  parameter int N_BTN      = 4,
  parameter int N_SW       = 10,
  parameter int N_LEDR     = 10,
  parameter int N_LEDG     = 8,
  parameter int DEB_CYCLES = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              oe,
  input  logic [ADDR_W-1:0] addr,
  input  logic [N_BTN-1:0]  buttons,
  input  logic [N_SW-1:0]   switches,
  output logic [N_LEDR-1:0] led_r,
  output logic [N_LEDG-1:0] led_g,
  output logic [4:0]        control_mem,
  inout  wire  [DATA_W-1:0] data
);

  localparam logic [ADDR_W-1:0] A_LEDG = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] A_LEDR = A_LEDG - ADDR_W'(1);
  localparam logic [ADDR_W-1:0] A_BTN  = A_LEDG - ADDR_W'(2);
  localparam logic [ADDR_W-1:0] A_SW   = A_LEDG - ADDR_W'(3);
  localparam logic [ADDR_W-1:0] A_EVT  = A_LEDG - ADDR_W'(4);

  // The counter only has to reach DEB_CYCLES-1, which always fits in clog2 bits.
  localparam int               CNT_W   = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);

  // SRAM strobe patterns {we, ce, oe, lb, ub}
  localparam logic [4:0] MEM_WRITE = 5'b00100;
  localparam logic [4:0] MEM_READ  = 5'b10000;
  localparam logic [4:0] MEM_IDLE  = 5'b11111;

  logic sel_ledg, sel_ledr, sel_btn, sel_sw, sel_evt, is_io;
  logic wr_ledg, wr_ledr, wr_evt;

  logic [N_BTN-1:0]  btn_p0, btn_p1;
  logic [N_SW-1:0]   sw_p0, sw_p1;
  logic [N_BTN-1:0]  btn_sync;

  logic [CNT_W-1:0]  deb_cnt  [N_BTN];
  logic [CNT_W-1:0]  cnt_next [N_BTN];
  logic [N_BTN-1:0]  btn_deb, deb_next, btn_rise;

  logic [N_BTN-1:0]  evt, evt_clr, evt_next;
  logic [DATA_W-1:0] rd_data;
  logic              unused_data;

  // Address decode and SRAM strobes (purely combinational, also during reset)
  assign sel_ledg = (addr == A_LEDG);
  assign sel_ledr = (addr == A_LEDR);
  assign sel_btn  = (addr == A_BTN);
  assign sel_sw   = (addr == A_SW);
  assign sel_evt  = (addr == A_EVT);
  assign is_io    = sel_ledg | sel_ledr | sel_btn | sel_sw | sel_evt;

  assign wr_ledg = oe & sel_ledg;
  assign wr_ledr = oe & sel_ledr;
  assign wr_evt  = oe & sel_evt;

  always_comb begin
    control_mem = MEM_IDLE;
    if (!is_io) begin
      control_mem = oe ? MEM_WRITE : MEM_READ;
    end
  end

  // Stage p0/p1: two-flop synchronisers. Button flops idle at the raw
  // released level (1) so the inverted output reads "not pressed" after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      btn_p0 <= '1;
      btn_p1 <= '1;
      sw_p0  <= '0;
      sw_p1  <= '0;
    end else begin
      btn_p0 <= buttons;
      btn_p1 <= btn_p0;
      sw_p0  <= switches;
      sw_p1  <= sw_p0;
    end
  end

  assign btn_sync = ~btn_p1;

  // Stage deb: per-button debounce. Any sample agreeing with the current
  // debounced state restarts the count, so only an uninterrupted run of
  // DEB_CYCLES differing samples moves the debounced level.
  always_comb begin
    deb_next = btn_deb;
    for (int i = 0; i < N_BTN; i++) begin
      cnt_next[i] = '0;
      if (btn_sync[i] != btn_deb[i]) begin
        if (deb_cnt[i] == CNT_MAX) begin
          deb_next[i] = btn_sync[i];
        end else begin
          cnt_next[i] = deb_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // A press sets its flag on the very edge the debounced level rises; OR-ing
  // the rise after the clear makes a simultaneous press win over the clear.
  assign btn_rise = deb_next & ~btn_deb;
  assign evt_clr  = wr_evt ? data[N_BTN-1:0] : '0;
  assign evt_next = (evt & ~evt_clr) | btn_rise;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      btn_deb <= '0;
      evt     <= '0;
      for (int i = 0; i < N_BTN; i++) begin
        deb_cnt[i] <= '0;
      end
    end else begin
      btn_deb <= deb_next;
      evt     <= evt_next;
      for (int i = 0; i < N_BTN; i++) begin
        deb_cnt[i] <= cnt_next[i];
      end
    end
  end

  // Stage reg: LED registers take the low bits of the bus on a CPU write
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      led_r <= '0;
      led_g <= '0;
    end else begin
      if (wr_ledr) begin
        led_r <= data[N_LEDR-1:0];
      end
      if (wr_ledg) begin
        led_g <= data[N_LEDG-1:0];
      end
    end
  end

  // Read path: zero-extended peripheral value, driven only for CPU reads of
  // an I/O address so the SRAM owns the bus everywhere else.
  always_comb begin
    rd_data = '0;
    if (sel_ledg) begin
      rd_data[N_LEDG-1:0] = led_g;
    end else if (sel_ledr) begin
      rd_data[N_LEDR-1:0] = led_r;
    end else if (sel_btn) begin
      rd_data[N_BTN-1:0] = btn_deb;
    end else if (sel_sw) begin
      rd_data[N_SW-1:0] = sw_p1;
    end else if (sel_evt) begin
      rd_data[N_BTN-1:0] = evt;
    end
  end

  assign data = (!oe && is_io) ? rd_data : {DATA_W{1'bz}};

  // Upper bus bits carry no meaning for the narrower registers.
  assign unused_data = ^data;

endmodule

// File: tb/tb_mmio_controller.sv
module tb_mmio_controller;

  localparam int DEB = 16;
  localparam logic [15:0] A_LEDG = 16'hFFFF;
  localparam logic [15:0] A_LEDR = 16'hFFFE;
  localparam logic [15:0] A_BTN  = 16'hFFFD;
  localparam logic [15:0] A_SW   = 16'hFFFC;
  localparam logic [15:0] A_EVT  = 16'hFFFB;

  logic        clk = 1'b0;
  logic        reset;
  logic        oe;
  logic [15:0] addr;
  logic [3:0]  buttons;
  logic [9:0]  switches;
  logic [9:0]  led_r;
  logic [7:0]  led_g;
  logic [4:0]  control_mem;
  wire  [15:0] data;
  logic [15:0] cpu_d;
  logic        cpu_drive;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [9:0] m_ledr;
  logic [7:0] m_ledg;
  logic [3:0] m_deb;
  logic [3:0] m_evt;
  logic [3:0] rq[$];   // raw pressed samples still inside the synchroniser
  logic [3:0] sh[$];   // last DEB synchronised samples seen by the debouncer

  assign data = cpu_drive ? cpu_d : 16'hzzzz;

  always #5 clk = ~clk;

  mmio_controller dut (
    .clk         (clk),
    .reset       (reset),
    .oe          (oe),
    .addr        (addr),
    .buttons     (buttons),
    .switches    (switches),
    .led_r       (led_r),
    .led_g       (led_g),
    .control_mem (control_mem),
    .data        (data)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    m_ledr = '0;
    m_ledg = '0;
    m_deb  = '0;
    m_evt  = '0;
    rq.delete();
    sh.delete();
    rq.push_back(4'h0);
    rq.push_back(4'h0);
  endfunction

  // One rising edge: a level moves once the synchronised input has
  // disagreed with it for DEB consecutive samples.
  function automatic void model_edge();
    logic [3:0] sync, nd, clr;
    bit         all_diff;
    sync = rq[0];
    void'(rq.pop_front());
    rq.push_back(~buttons);
    sh.push_back(sync);
    if (sh.size() > DEB) void'(sh.pop_front());
    nd = m_deb;
    if (sh.size() == DEB) begin
      for (int i = 0; i < 4; i++) begin
        all_diff = 1'b1;
        foreach (sh[j]) if (sh[j][i] == m_deb[i]) all_diff = 1'b0;
        if (all_diff) nd[i] = sync[i];
      end
    end
    clr   = (oe && addr == A_EVT) ? cpu_d[3:0] : 4'h0;
    m_evt = (m_evt & ~clr) | (nd & ~m_deb);
    m_deb = nd;
    if (oe && addr == A_LEDR) m_ledr = cpu_d[9:0];
    if (oe && addr == A_LEDG) m_ledg = cpu_d[7:0];
  endfunction

  task automatic tick();
    if (reset) model_reset();
    else model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    oe = 1'b1; addr = a; cpu_d = d; cpu_drive = 1'b1;
    tick();
    oe = 1'b0; cpu_drive = 1'b0; addr = 16'h0000;
  endtask

  task automatic rd_chk(input string tag, input logic [15:0] a, input logic [15:0] exp);
    oe = 1'b0; cpu_drive = 1'b0; addr = a;
    #1;
    chk(tag, data, exp);
  endtask

  initial begin
    logic [15:0] d;
    int          hold;
    bit          hz;

    reset = 1'b1; oe = 1'b0; addr = 16'h0000; buttons = 4'hF; switches = '0;
    cpu_d = '0; cpu_drive = 1'b0;
    model_reset();
    tick(); tick();
    chk("rst_led_r", led_r, 10'h000);
    chk("rst_led_g", led_g, 8'h00);
    rd_chk("rst_evt", A_EVT, 16'h0000);
    chk("rst_ctl_io", control_mem, 5'b11111);
    reset = 1'b0;
    tick(); tick();

    // SRAM strobes and bus release
    oe = 1'b1; addr = 16'h1234; #1;
    chk("ctl_mem_wr", control_mem, 5'b00100);
    hz = (data === 16'hzzzz);
    chk("hiz_mem_wr", hz, 1'b1);
    oe = 1'b0; #1;
    chk("ctl_mem_rd", control_mem, 5'b10000);
    hz = (data === 16'hzzzz);
    chk("hiz_mem_rd", hz, 1'b1);
    oe = 1'b1; addr = A_LEDR; #1;
    chk("ctl_io_wr", control_mem, 5'b11111);
    hz = (data === 16'hzzzz);
    chk("hiz_io_wr", hz, 1'b1);
    oe = 1'b0; addr = 16'h0000;

    // LED registers
    wr(A_LEDR, 16'h03FF);
    chk("ledr_3ff", led_r, 10'h3FF);
    rd_chk("rd_ledr_3ff", A_LEDR, 16'h03FF);
    chk("ctl_io_rd", control_mem, 5'b11111);
    for (int k = 0; k < 8; k++) begin
      d = 16'($urandom);
      if (k[0]) wr(A_LEDG, d);
      else wr(A_LEDR, d);
      chk("led_r", led_r, m_ledr);
      chk("led_g", led_g, m_ledg);
      rd_chk("rd_ledr", A_LEDR, {6'h0, m_ledr});
      rd_chk("rd_ledg", A_LEDG, {8'h0, m_ledg});
    end

    // Switches through the synchroniser
    for (int k = 0; k < 4; k++) begin
      switches = 10'($urandom);
      tick(); tick(); tick();
      rd_chk("rd_sw", A_SW, {6'h0, switches});
    end

    // Read-only addresses ignore writes
    wr(A_BTN, 16'hFFFF);
    wr(A_SW, 16'hFFFF);
    rd_chk("ro_btn", A_BTN, {12'h0, m_deb});
    rd_chk("ro_sw", A_SW, {6'h0, switches});

    // Button 0 held 20 cycles
    buttons = 4'b1110;
    for (int k = 1; k <= 20; k++) begin
      tick();
      rd_chk("b0_press_model", A_BTN, {12'h0, m_deb});
      if (k == 17) rd_chk("b0_not_yet", A_BTN, 16'h0000);
      if (k == 18) rd_chk("b0_level", A_BTN, 16'h0001);
    end
    rd_chk("b0_evt", A_EVT, 16'h0001);
    buttons = 4'hF;
    repeat (20) tick();
    rd_chk("b0_released", A_BTN, 16'h0000);
    rd_chk("b0_evt_sticky", A_EVT, 16'h0001);

    // Glitch on button 1
    buttons = 4'b1101;
    repeat (5) tick();
    buttons = 4'hF;
    for (int k = 0; k < 25; k++) begin
      tick();
      rd_chk("glitch_lvl", A_BTN, 16'h0000);
    end
    rd_chk("glitch_evt", A_EVT, 16'h0001);

    // Button 1 real press
    buttons = 4'b1101;
    repeat (20) tick();
    rd_chk("b1_level", A_BTN, 16'h0002);
    rd_chk("b1_evt", A_EVT, 16'h0003);
    buttons = 4'hF;
    repeat (20) tick();
    rd_chk("b1_evt_sticky", A_EVT, 16'h0003);

    // Write-1-to-clear
    wr(A_EVT, 16'h0001);
    rd_chk("w1c_bit0", A_EVT, 16'h0002);
    wr(A_EVT, 16'hFFF0);
    rd_chk("w1c_upper_ignored", A_EVT, 16'h0002);

    // Clear landing on the same edge as a new bit0 press
    buttons = 4'b1110;
    repeat (17) tick();
    rd_chk("coll_pre", A_EVT, 16'h0002);
    wr(A_EVT, 16'h0001);
    rd_chk("coll_set_wins", A_EVT, 16'h0003);
    rd_chk("coll_model", A_EVT, {12'h0, m_evt});
    buttons = 4'hF;
    repeat (20) tick();

    // Randomised buttons and clears against the model
    hold = 0;
    for (int c = 0; c < 300; c++) begin
      if (hold == 0) begin
        buttons = 4'($urandom);
        hold = $urandom_range(1, 24);
      end
      hold--;
      if ($urandom_range(0, 7) == 0) wr(A_EVT, 16'($urandom));
      else tick();
      rd_chk("rnd_btn", A_BTN, {12'h0, m_deb});
      rd_chk("rnd_evt", A_EVT, {12'h0, m_evt});
    end
    buttons = 4'hF;
    repeat (20) tick();

    // Asynchronous reset mid-cycle and mid-debounce
    wr(A_LEDG, 16'hFFA5);
    chk("ledg_a5", led_g, 8'hA5);
    buttons = 4'b1110;
    repeat (20) tick();
    buttons = 4'hF;
    repeat (20) tick();
    rd_chk("pre_rst_evt", A_EVT, {12'h0, m_evt});
    buttons = 4'b1011;
    repeat (14) tick();
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    chk("async_ledg", led_g, 8'h00);
    chk("async_ledr", led_r, 10'h000);
    rd_chk("async_evt", A_EVT, 16'h0000);
    rd_chk("async_btn", A_BTN, 16'h0000);
    addr = 16'h0042; #1;
    chk("rst_ctl_mem", control_mem, 5'b10000);
    tick(); tick();
    reset = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      rd_chk("post_rst_lvl", A_BTN, 16'h0000);
    end
    buttons = 4'hF;
    repeat (20) tick();
    rd_chk("post_rst_evt", A_EVT, 16'h0000);
    rd_chk("post_rst_model", A_EVT, {12'h0, m_evt});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
